lif_spike_monitor: RTL and testbench

- Downstream stage of the LIF neuron core; consumes its spike output and produces two measurements.
- Measurement 1: spike count over a programmable window (rate).
- Measurement 2: inter-spike interval (ISI) between consecutive spike rising edges.
- Results are registered with one-cycle valid pulses, ready for the tile's uo_out/uio_out mux.

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_isi_meter.sv | 45 ++++
 rtl/lif_spike_monitor.sv | 110 +++++++++++
 tb/tb_lif_spike_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types, default widths and helpers for the LIF spike monitor.
package lif_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_ISI_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Increment that sticks at max_v instead of wrapping; callers cast to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lif_isi_meter.sv
// Inter-spike interval meter: cycles between consecutive rising edges, saturating.
module lif_isi_meter
  import lif_pkg::*;
#(
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_i,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid_o
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_cnt_inc;
  logic             isi_armed;

  assign isi_cnt_inc = ISI_W'(sat_inc(32'(isi_cnt), 32'(ISI_MAX)));

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt     <= '0;
      isi_armed   <= 1'b0;
      isi_o       <= '0;
      isi_valid_o <= 1'b0;
    end else begin
      isi_valid_o <= 1'b0;
      if (edge_i) begin
        // The counter lags the edge by one cycle, so the interval is count+1.
        if (isi_armed) begin
          isi_o       <= isi_cnt_inc;
          isi_valid_o <= 1'b1;
        end
        isi_cnt   <= '0;
        isi_armed <= 1'b1;
      end else begin
        isi_cnt <= isi_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Spike rate over a programmable window plus inter-spike interval, both with
// one-cycle valid pulses; sits downstream of the LIF neuron core.
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic [WIN_W-1:0] win_len_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid_o,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               TMR_W   = WIN_W + 1;

  state_t           state, state_d;
  logic             spike_q;
  logic             spike_edge;
  logic [TMR_W-1:0] win_len_ext;
  logic [TMR_W-1:0] win_len_q, win_len_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [CNT_W-1:0] count, count_d, count_inc;
  logic [CNT_W-1:0] rate_d;
  logic             rate_valid_d;

  assign spike_edge  = spike_i & ~spike_q;
  // A zero length stands for the full 2^WIN_W window, hence the extra timer bit.
  assign win_len_ext = (win_len_i == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_len_i};
  assign count_inc   = spike_edge ? CNT_W'(sat_inc(32'(count), 32'(CNT_MAX))) : count;
  assign busy_o      = (state == COUNT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    win_len_d    = win_len_q;
    timer_d      = timer;
    count_d      = count;
    rate_d       = rate_o;
    rate_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          win_len_d = win_len_ext;
          timer_d   = win_len_ext;
          count_d   = '0;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (timer == TMR_W'(1)) begin
          // Last window cycle: its edge is folded into the published count.
          rate_d       = count_inc;
          rate_valid_d = 1'b1;
          count_d      = '0;
          if (cont_i) begin
            timer_d = win_len_q;
          end else begin
            timer_d = '0;
            state_d = IDLE;
          end
        end else begin
          count_d = count_inc;
          timer_d = timer - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      spike_q      <= 1'b0;
      win_len_q    <= '0;
      timer        <= '0;
      count        <= '0;
      rate_o       <= '0;
      rate_valid_o <= 1'b0;
    end else begin
      state        <= state_d;
      spike_q      <= spike_i;
      win_len_q    <= win_len_d;
      timer        <= timer_d;
      count        <= count_d;
      rate_o       <= rate_d;
      rate_valid_o <= rate_valid_d;
    end
  end

  lif_isi_meter #(
    .ISI_W(ISI_W)
  ) u_isi (
    .clk        (clk),
    .rst        (rst),
    .edge_i     (spike_edge),
    .isi_o      (isi_o),
    .isi_valid_o(isi_valid_o)
  );

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Scoreboard bench for lif_spike_monitor: expected rate/ISI results are queued
// as stimulus is driven and popped when the valid pulses appear.
module tb_lif_spike_monitor;

  localparam int CNT_W = 8;
  localparam int WIN_W = 8;
  localparam int ISI_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             spike_i;
  logic             start_i;
  logic             cont_i;
  logic [WIN_W-1:0] win_len_i;
  logic [CNT_W-1:0] rate_o;
  logic             rate_valid_o;
  logic [ISI_W-1:0] isi_o;
  logic             isi_valid_o;
  logic             busy_o;

  // Second instance with a longer window so more than 255 edges fit in one window.
  logic             sat_start;
  logic [9:0]       sat_win_len;
  logic [7:0]       sat_rate;
  logic             sat_rate_valid;
  logic [7:0]       sat_isi;
  logic             sat_isi_valid;
  logic             sat_busy;

  lif_spike_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .spike_i     (spike_i),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .win_len_i   (win_len_i),
    .rate_o      (rate_o),
    .rate_valid_o(rate_valid_o),
    .isi_o       (isi_o),
    .isi_valid_o (isi_valid_o),
    .busy_o      (busy_o)
  );

  lif_spike_monitor #(.CNT_W(8), .WIN_W(10), .ISI_W(8)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .spike_i     (spike_i),
    .start_i     (sat_start),
    .cont_i      (1'b0),
    .win_len_i   (sat_win_len),
    .rate_o      (sat_rate),
    .rate_valid_o(sat_rate_valid),
    .isi_o       (sat_isi),
    .isi_valid_o (sat_isi_valid),
    .busy_o      (sat_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t rate_q[$];
  exp_t isi_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sat_pulses = 0;
  int   sat_exp_cyc = -1;
  int   sat_isi_pulses = 0;
  int   isi_pushes = 0;
  int   last_isi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ISI reference: interval is the cycle distance between driven rising edges.
  logic m_prev = 1'b0;
  bit   m_armed = 1'b0;
  int   m_last = 0;
  always @(posedge clk) begin : isi_model
    int d;
    if (rst) begin
      m_prev  = 1'b0;
      m_armed = 1'b0;
    end else begin
      if (spike_i && !m_prev) begin
        if (m_armed) begin
          d = cyc - m_last;
          if (d > 255) d = 255;
          isi_q.push_back('{d, cyc + 1});
          isi_pushes++;
          last_isi = d;
        end
        m_armed = 1'b1;
        m_last  = cyc;
      end
      m_prev = spike_i;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (rate_valid_o) begin
        check("rate_pulse_expected", 32'(rate_q.size() > 0), 1);
        if (rate_q.size() > 0) begin
          e = rate_q.pop_front();
          check("rate_value", 32'(rate_o), e.val);
          check("rate_cycle", cyc, e.cyc);
        end
      end
      if (isi_valid_o) begin
        check("isi_pulse_expected", 32'(isi_q.size() > 0), 1);
        if (isi_q.size() > 0) begin
          e = isi_q.pop_front();
          check("isi_value", 32'(isi_o), e.val);
          check("isi_cycle", cyc, e.cyc);
        end
      end
      if (sat_rate_valid) begin
        sat_pulses++;
        check("sat_rate_value", 32'(sat_rate), 255);
        check("sat_rate_cycle", cyc, sat_exp_cyc);
      end
      if (sat_isi_valid) sat_isi_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      spike_i   = 1'b0;
      start_i   = 1'b0;
      sat_start = 1'b0;
    end
  endtask

  initial begin
    int r;
    int c0;
    rst         = 1'b1;
    spike_i     = 1'b0;
    start_i     = 1'b0;
    cont_i      = 1'b0;
    win_len_i   = '0;
    sat_start   = 1'b0;
    sat_win_len = '0;
    repeat (3) tick();

    check("rst_rate", 32'(rate_o), 0);
    check("rst_rate_valid", 32'(rate_valid_o), 0);
    check("rst_isi", 32'(isi_o), 0);
    check("rst_isi_valid", 32'(isi_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
    r   = cyc;

    // ISI: edges at r+10, r+15, r+400 (FSM idle throughout).
    for (int k = 1; k <= 402; k++) begin
      tick();
      spike_i = (cyc == r + 10) || (cyc == r + 15) || (cyc == r + 400);
      if (cyc == r + 11) check("isi_first_edge_arms_only", 32'(isi_valid_o), 0);
      if (cyc == r + 16) check("isi_short_interval", 32'(isi_o), 5);
    end
    spike_i = 1'b0;
    idle(2);
    check("isi_saturated_interval", 32'(isi_o), 255);

    // Window of 10 with edges on cycles 1, 4 and 10.
    tick();
    start_i = 1'b1; win_len_i = 8'd10; c0 = cyc;
    rate_q.push_back('{3, c0 + 11});
    for (int w = 1; w <= 11; w++) begin
      tick();
      start_i = 1'b0;
      spike_i = (w == 1) || (w == 4) || (w == 10);
      if (w == 1)  check("t1_busy_first", 32'(busy_o), 1);
      if (w == 11) check("t1_busy_after_end", 32'(busy_o), 0);
    end

    // Held-high spike counts once.
    idle(3);
    tick();
    start_i = 1'b1; win_len_i = 8'd20; c0 = cyc;
    rate_q.push_back('{1, c0 + 21});
    for (int w = 1; w <= 21; w++) begin
      tick();
      start_i = 1'b0;
      spike_i = (w >= 3) && (w <= 8);
    end

    // win_len=0 (256 cycles) -> 128; 600-cycle window on dut_sat -> saturates at 255.
    idle(3);
    tick();
    start_i = 1'b1; win_len_i = 8'd0; sat_start = 1'b1; sat_win_len = 10'd600; c0 = cyc;
    rate_q.push_back('{128, c0 + 257});
    sat_exp_cyc = c0 + 601;
    for (int w = 1; w <= 602; w++) begin
      tick();
      start_i   = 1'b0;
      sat_start = 1'b0;
      spike_i   = (w <= 599) && (w % 2 == 1);
      if (w == 256) check("t3_busy_last", 32'(busy_o), 1);
      if (w == 257) check("t3_busy_after", 32'(busy_o), 0);
      if (w == 600) check("sat_busy_last", 32'(sat_busy), 1);
      if (w == 601) check("sat_busy_after", 32'(sat_busy), 0);
    end

    // Continuous mode, length 5, spikes every third cycle incl. the first reload cycle.
    idle(3);
    tick();
    start_i = 1'b1; win_len_i = 8'd5; cont_i = 1'b1; c0 = cyc;
    rate_q.push_back('{1, c0 + 6});
    rate_q.push_back('{2, c0 + 11});
    rate_q.push_back('{2, c0 + 16});
    rate_q.push_back('{1, c0 + 21});
    for (int w = 1; w <= 22; w++) begin
      tick();
      start_i = 1'b0;
      cont_i  = (w <= 15);
      spike_i = (w % 3 == 0) && (w <= 18);
      if (w == 16) check("cont_busy_mid", 32'(busy_o), 1);
      if (w == 21) check("cont_busy_end", 32'(busy_o), 0);
    end

    // Reset mid-window with count=4.
    idle(3);
    tick();
    start_i = 1'b1; win_len_i = 8'd30; c0 = cyc;
    for (int w = 1; w <= 9; w++) begin
      tick();
      start_i = 1'b0;
      spike_i = (w == 2) || (w == 4) || (w == 6) || (w == 8);
    end
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_rate", 32'(rate_o), 0);
    check("mid_rst_rate_valid", 32'(rate_valid_o), 0);
    check("mid_rst_isi", 32'(isi_o), 0);
    check("mid_rst_isi_valid", 32'(isi_valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_rate_q_empty", rate_q.size(), 0);
    tick();
    tick();
    rst = 1'b0;
    idle(35);
    tick();
    start_i = 1'b1; win_len_i = 8'd4; c0 = cyc;
    rate_q.push_back('{1, c0 + 5});
    for (int w = 1; w <= 5; w++) begin
      tick();
      start_i = 1'b0;
      spike_i = (w == 2);
    end

    // start_i and win_len_i changes during COUNT are ignored.
    idle(3);
    tick();
    start_i = 1'b1; win_len_i = 8'd8; c0 = cyc;
    rate_q.push_back('{1, c0 + 9});
    for (int w = 1; w <= 10; w++) begin
      tick();
      start_i   = (w == 3) || (w == 5);
      win_len_i = (w >= 3) ? 8'd3 : 8'd8;
      spike_i   = (w == 2);
      if (w == 8) check("ign_busy_last", 32'(busy_o), 1);
      if (w == 9) check("ign_busy_after", 32'(busy_o), 0);
    end
    start_i = 1'b0;

    idle(5);
    check("rate_q_drained", rate_q.size(), 0);
    check("isi_q_drained", isi_q.size(), 0);
    check("sat_single_pulse", sat_pulses, 1);
    check("sat_isi_pulse_count", sat_isi_pulses, isi_pushes);
    check("isi_last_value", 32'(isi_o), last_isi);
    check("sat_isi_last_value", 32'(sat_isi), last_isi);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
